seq_alu_hs: RTL and testbench
=============================

Name: seq_alu_hs

Overview:
Parametrised, handshaked successor to the team's combinational signed/unsigned ALU. It accepts one instruction per valid/ready handshake and registers a double-width result. Add, sub, mul and shift complete in 1 cycle; divide runs iteratively over WIDTH cycles. Sits between an instruction source and a result consumer, both using valid/ready flow control.

Parameters:
WIDTH, 32, operand width in bits (>=4, power of 2).
SHW, $clog2(WIDTH), shift-amount width (derived, not overridden).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  instruction valid.
in_ready  out  1  block can accept an instruction this cycle.
in_opc  in  opcode_t  add, sub, mul, div, sl, sr.
in_op_type  in  operand_type_t  sign or unsign.
in_op_a  in  WIDTH  operand A / dividend / shift source.
in_op_b  in  WIDTH  operand B / divisor; bits [SHW-1:0] are the shift amount.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
out_result  out  2*WIDTH  result; for div, {remainder, quotient}.
out_dz  out  1  divide-by-zero flag, qualified by out_valid.
busy  out  1  divide in progress.

Behaviour:
- Reset, asynchronous, active-low, clears: state=IDLE; out_valid=0; out_result=0; out_dz=0; busy=0. in_ready is 1 once rst_n is high.
- Reset asserted mid-divide aborts the operation. No result is produced.
- States: IDLE, DIV, DONE.
- in_ready = (state==IDLE) && (!out_valid || out_ready). The held result can drain and a new instruction can be accepted in the same cycle.
- Accept: in_valid && in_ready. Operands, opc and op_type are captured.
- Non-div op in IDLE: result is registered at the accept edge, so out_valid=1 on the next cycle (latency 1). Back-to-back throughput is 1 per cycle while out_ready=1.
- Div with in_op_b!=0: IDLE->DIV, busy=1. The iterative unsigned restoring divider runs on magnitudes for exactly WIDTH cycles, then DIV->DONE.
- DONE: sign fix-up is applied, the result is registered, out_valid=1 and busy=0, then state returns to IDLE. Total latency from accept to out_valid is WIDTH+2 cycles.
- Div with in_op_b==0: no iteration. The result is registered with latency 1: quotient = all ones, remainder = op_a, out_dz=1.
- out_valid holds, with out_result stable, until out_ready=1. in_ready=0 during DIV and DONE, and while an unconsumed result is held.
- Arithmetic, sign mode: operands are sign-extended to 2*WIDTH. add/sub give the exact 2*WIDTH result. mul gives the full signed product. sl is arithmetic left shift of A by shamt, sign-extended. sr is arithmetic right shift (>>>).
- Arithmetic, unsign mode: operands are zero-extended. add keeps the carry in bit WIDTH. sub gives the 2*WIDTH two's-complement difference. mul gives the full product. sl/sr are logical shifts; the result is zero-extended.
- Signed div truncates toward zero; the remainder takes the sign of the dividend. MIN / -1 gives quotient=MIN, remainder=0, out_dz=0.
- Shift amount 0 passes A through extended. Only op_b[SHW-1:0] is used.
- out_dz=0 for all non-div ops.

Decomposition:
- Package alu_pkg: opcode_t {add,sub,mul,div,sl,sr}; operand_type_t {sign,unsign}; state enum.
- Width-dependent unions (data_t, l_data_t equivalents) are declared locally in the module, since they depend on WIDTH.
- One sub-module, seq_divider: unsigned restoring divider, parameter WIDTH; ports start, dividend, divisor, done, quotient, remainder. clk and rst_n are shared with the top.

Test Plan:
1. WIDTH=8, unsign add 0xFF+0x01, out_ready=1 -> out_valid one cycle after accept, out_result=0x0100, out_dz=0.
2. WIDTH=8, sign mul -3*5 -> out_result=0xFFF1. Then unsign mul 0xFF*0xFF issued next cycle -> out_result=0xFE01. Back-to-back, in_ready stays 1.
3. WIDTH=8, sign div -7/2 -> busy=1 for the divide, out_valid 10 cycles after accept, result {rem=0xFF, quo=0xFD}. in_ready=0 throughout.
4. WIDTH=8, div 0x2A/0 -> out_valid at latency 1, quotient 0xFF, remainder 0x2A, out_dz=1.
5. WIDTH=8, sign sr 0x80 by 3 -> 0xFFF0. Unsign sr 0x80 by 3 -> 0x0010. Hold out_ready=0 for 4 cycles: out_result stable, in_ready=0, no instruction lost.
6. Start div 100/7, assert rst_n=0 on cycle 4 of DIV -> out_valid=0, busy=0 immediately. After release, add 1+1 -> 0x0002.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode, operand-type and control-state enums shared by the sequential ALU
package alu_pkg;
   typedef enum logic [2:0] {add, sub, mul, div, sl, sr} opcode_t;
   typedef enum logic {sign, unsign} operand_type_t;
   typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
endpackage

// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider producing one quotient bit per cycle
module seq_divider #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);
   localparam int CW = $clog2(WIDTH) + 1;
   logic [WIDTH-1:0] quo, rem, dvs;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   trial;
   assign trial     = {rem, quo[WIDTH-1]} - {1'b0, dvs};
   assign done      = cnt == CW'(1);
   assign quotient  = quo;
   assign remainder = rem;
   // load on start, then shift-and-subtract until the count runs out; done marks the final step
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         quo <= '0;
         rem <= '0;
         dvs <= '0;
         cnt <= '0;
      end else if (start) begin
         quo <= dividend;
         rem <= '0;
         dvs <= divisor;
         cnt <= CW'(WIDTH);
      end else if (cnt != '0) begin
         cnt <= cnt - CW'(1);
         rem <= trial[WIDTH] ? {rem[WIDTH-2:0], quo[WIDTH-1]} : trial[WIDTH-1:0];
         quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
      end
endmodule

// File: rtl/seq_alu_hs.sv
// seq_alu_hs: valid/ready ALU, single-cycle add/sub/mul/shift, WIDTH-cycle divide
module seq_alu_hs
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  opcode_t              in_opc,
   input  operand_type_t        in_op_type,
   input  logic [WIDTH-1:0]     in_op_a,
   input  logic [WIDTH-1:0]     in_op_b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   out_result,
   output logic                 out_dz,
   output logic                 busy
);
   localparam int SHW = $clog2(WIDTH);
   typedef logic [WIDTH-1:0]   data_t;
   typedef logic [2*WIDTH-1:0] l_data_t;

   state_t         state, state_nx;
   logic           sgn, accept, div_start, div_done, q_neg, r_neg;
   logic [SHW-1:0] shamt;
   data_t          mag_a, mag_b, quo, rem, quo_fix, rem_fix, sra_w, srl_w, sl_w;
   l_data_t        ea, eb, res;

   function automatic l_data_t ext(input data_t v, input logic s);
      return {{WIDTH{s & v[WIDTH-1]}}, v};
   endfunction

   assign sgn       = in_op_type == sign;
   assign in_ready  = state == IDLE && (!out_valid || out_ready);
   assign accept    = in_valid && in_ready;
   assign div_start = accept && in_opc == div && in_op_b != '0;
   assign busy      = state != IDLE;
   assign shamt     = in_op_b[SHW-1:0];
   assign mag_a     = sgn && in_op_a[WIDTH-1] ? -in_op_a : in_op_a;
   assign mag_b     = sgn && in_op_b[WIDTH-1] ? -in_op_b : in_op_b;
   assign ea        = ext(in_op_a, sgn);
   assign eb        = ext(in_op_b, sgn);
   assign sra_w     = $signed(in_op_a) >>> shamt;
   assign srl_w     = in_op_a >> shamt;
   assign sl_w      = in_op_a << shamt;
   assign quo_fix   = q_neg ? -quo : quo;
   assign rem_fix   = r_neg ? -rem : rem;

   seq_divider #(.WIDTH(WIDTH)) u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (div_start),
      .dividend  (mag_a),
      .divisor   (mag_b),
      .done      (div_done),
      .quotient  (quo),
      .remainder (rem)
   );

   // single-cycle result; a divide reaching here has a zero divisor
   always_comb begin
      case (in_opc)
         add:     res = ea + eb;
         sub:     res = ea - eb;
         mul:     res = ea * eb;
         sl:      res = ext(sl_w, sgn);
         sr:      res = ext(sgn ? sra_w : srl_w, sgn);
         default: res = {in_op_a, {WIDTH{1'b1}}};
      endcase
   end

   // control state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;

   // divide sequencing: iterate in DIV, publish the fixed-up result from DONE
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = div_start ? DIV : IDLE;
         DIV:     state_nx = div_done ? DONE : DIV;
         default: state_nx = IDLE;
      endcase
   end

   // remember result signs for the fix-up, since the divider works on magnitudes
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         q_neg <= 1'b0;
         r_neg <= 1'b0;
      end else if (div_start) begin
         q_neg <= sgn && (in_op_a[WIDTH-1] ^ in_op_b[WIDTH-1]);
         r_neg <= sgn && in_op_a[WIDTH-1];
      end

   // output holding register: load on a single-cycle accept or from DONE, clear once consumed
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_result <= '0;
         out_dz     <= 1'b0;
      end else if (accept && !div_start) begin
         out_valid  <= 1'b1;
         out_result <= res;
         out_dz     <= in_opc == div;
      end else if (state == DONE) begin
         out_valid  <= 1'b1;
         out_result <= {rem_fix, quo_fix};
         out_dz     <= 1'b0;
      end else if (out_ready) begin
         out_valid  <= 1'b0;
      end
endmodule

// File: tb/tb_seq_alu_hs.sv
// tb_seq_alu_hs: directed vectors for seq_alu_hs at WIDTH=8
module tb_seq_alu_hs;
   import alu_pkg::*;
   localparam int W = 8;

   logic          clk = 1'b0;
   logic          rst_n, in_valid, in_ready, out_valid, out_ready, out_dz, busy;
   opcode_t       in_opc;
   operand_type_t in_op_type;
   logic [W-1:0]  in_op_a, in_op_b;
   logic [2*W-1:0] out_result;
   int            vectors = 0, miscompares = 0;

   seq_alu_hs #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_opc     (in_opc),
      .in_op_type (in_op_type),
      .in_op_a    (in_op_a),
      .in_op_b    (in_op_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_dz     (out_dz),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic drive(input opcode_t o, input operand_type_t t, input logic [W-1:0] a, input logic [W-1:0] b);
      in_valid   = 1'b1;
      in_opc     = o;
      in_op_type = t;
      in_op_a    = a;
      in_op_b    = b;
   endtask

   // latency-1 op with out_ready high: result appears one cycle after accept, then drains
   task automatic one(input string tag, input opcode_t o, input operand_type_t t,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2*W-1:0] expv, input logic dz);
      drive(o, t, a, b);
      chk({tag, "_ready"}, in_ready, 1);
      step();
      in_valid = 1'b0;
      chk(tag, {out_valid, out_dz, out_result}, {1'b1, dz, expv});
      step();
   endtask

   // divide with nonzero divisor: bounded wait, latency must be W+2
   task automatic div_op(input string tag, input operand_type_t t,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic [2*W-1:0] expv);
      int lat;
      drive(div, t, a, b);
      step();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         step();
         lat++;
      end
      chk({tag, "_lat"}, 64'(lat), 64'(W + 2));
      chk(tag, {out_valid, busy, out_dz, out_result}, {3'b100, expv});
      step();
   endtask

   initial begin
      bit seen;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      in_opc = add; in_op_type = unsign; in_op_a = '0; in_op_b = '0;
      step();
      step();
      chk("reset", {out_valid, busy, out_dz, out_result}, 0);
      rst_n = 1'b1;
      #1;
      chk("reset_ready", in_ready, 1);

      one("add_u_carry", add, unsign, 8'hFF, 8'h01, 16'h0100, 1'b0);
      one("add_s", add, sign, 8'h7F, 8'h01, 16'h0080, 1'b0);
      one("sub_s", sub, sign, 8'h80, 8'h01, 16'hFF7F, 1'b0);
      one("sub_u", sub, unsign, 8'h01, 8'h02, 16'hFFFF, 1'b0);
      one("mul_s_min", mul, sign, 8'h80, 8'h80, 16'h4000, 1'b0);
      one("sl_u", sl, unsign, 8'h03, 8'h02, 16'h000C, 1'b0);
      one("sl_s", sl, sign, 8'hFD, 8'h01, 16'hFFFA, 1'b0);
      one("sr_s_sh0", sr, sign, 8'h85, 8'h00, 16'hFF85, 1'b0);
      one("sr_u_lowbits", sr, unsign, 8'h80, 8'h0B, 16'h0010, 1'b0);

      drive(mul, sign, 8'hFD, 8'h05);
      step();
      chk("mul_s", {out_valid, in_ready, out_result}, {2'b11, 16'hFFF1});
      drive(mul, unsign, 8'hFF, 8'hFF);
      step();
      in_valid = 1'b0;
      chk("mul_u_b2b", {out_valid, out_result}, {1'b1, 16'hFE01});
      step();
      chk("b2b_drained", out_valid, 0);

      drive(div, sign, 8'hF9, 8'h02);
      step();
      in_valid = 1'b0;
      for (int c = 1; c <= W + 1; c++) begin
         chk($sformatf("div_cyc%0d", c), {busy, in_ready, out_valid}, 3'b100);
         step();
      end
      chk("div_s_m7_2", {out_valid, busy, out_dz, out_result}, {3'b100, 16'hFFFD});
      step();

      one("div_zero", div, unsign, 8'h2A, 8'h00, 16'h2AFF, 1'b1);
      chk("div_zero_busy", busy, 0);
      div_op("div_min_m1", sign, 8'h80, 8'hFF, 16'h0080);
      div_op("div_u_100_7", unsign, 8'h64, 8'h07, 16'h020E);
      div_op("div_s_7_m2", sign, 8'h07, 8'hFE, 16'h01FD);
      div_op("div_s_m7_m2", sign, 8'hF9, 8'hFE, 16'hFF03);

      out_ready = 1'b0;
      drive(sr, sign, 8'h80, 8'h03);
      step();
      chk("sr_s", {out_valid, out_result}, {1'b1, 16'hFFF0});
      drive(sr, unsign, 8'h80, 8'h03);
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("hold%0d", c), {out_valid, in_ready, out_result}, {2'b10, 16'hFFF0});
         step();
      end
      out_ready = 1'b1;
      #1;
      chk("drain_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      chk("sr_u", {out_valid, out_result}, {1'b1, 16'h0010});
      step();
      chk("sr_drained", out_valid, 0);

      drive(div, unsign, 8'h64, 8'h07);
      step();
      in_valid = 1'b0;
      step();
      step();
      step();
      chk("abort_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("abort", {out_valid, busy}, 0);
      step();
      step();
      rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < W + 4; c++) begin
         seen |= out_valid | busy;
         step();
      end
      chk("abort_no_result", seen, 0);
      one("post_rst_add", add, unsign, 8'h01, 8'h01, 16'h0002, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
